whack_round_ctrl: RTL and testbench

- Game-round sequencer for the whack-a-mole core.
- Drives one external interval counter in count-down mode: selects the mole, loads the interval, restarts the timer, and judges hit vs timeout.
- Tracks score, misses and difficulty level; declares game over.
- Sits between the debounced button block and the interval counter / display logic.

---
 rtl/whack_round_ctrl.sv | 176 +++++++++++++++++
 tb/tb_whack_round_ctrl.sv | 196 +++++++++++++++++++
 2 files changed

// File: rtl/whack_round_ctrl.sv
// Whack-a-mole round sequencer: spawns moles, drives a count-down interval timer, scores hits and misses.
// Optional WRONG_HIT_PENALTY_EN: a wrong-button press in WAIT costs a miss and can end the game at once.
//
// state | meaning
// IDLE  | powered up, waiting for start
// SPAWN | pick next mole (1 cycle), timer held in restart
// WAIT  | mole lit, timer running, waiting for hit or timeout
// GAP   | blank pause between rounds
// DONE  | game over, waiting for start
module whack_round_ctrl #(
    parameter int NUM_MOLES      = 8,
    parameter int ROUNDS         = 16,
    parameter int MAX_MISSES     = 5,
    parameter int START_INTERVAL = 5,
    parameter int LEVEL_HITS     = 4,
    parameter int GAP_CYCLES     = 4
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 start,
    input  logic [NUM_MOLES-1:0] hit,
    input  logic                 tmr_timeout,
    output logic                 tmr_rst_n,
    output logic [2:0]           tmr_interval,
    output logic                 tmr_dir,
    output logic [NUM_MOLES-1:0] mole,
    output logic [7:0]           score,
    output logic [3:0]           misses,
    output logic [7:0]           round_cnt,
    output logic                 busy,
    output logic                 game_over
);

    localparam int GW = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
    localparam logic [3:0]    MAX_M     = 4'(MAX_MISSES);
    localparam logic [7:0]    ROUNDS_L  = 8'(ROUNDS);
    localparam logic [7:0]    LEVEL_L   = 8'(LEVEL_HITS);
    localparam logic [2:0]    START_INT = 3'(START_INTERVAL);
    localparam logic [2:0]    LAST_IDX  = 3'(NUM_MOLES - 1);
    localparam logic [GW-1:0] GAP_LOAD  = GW'(GAP_CYCLES - 1);

    typedef enum logic [2:0] {S_IDLE, S_SPAWN, S_WAIT, S_GAP, S_DONE} state_t;

    state_t          r_state;
    state_t          w_state_nxt;
    logic [15:0]     r_lfsr;
    logic [2:0]      r_prev_mole;
    logic [1:0]      r_blank_cnt;
    logic [GW-1:0]   r_gap_cnt;
    logic [7:0]      r_score;
    logic [3:0]      r_misses;
    logic [7:0]      r_round;
    logic [2:0]      r_interval;

    logic [2:0]           w_idx_raw;
    logic [2:0]           w_idx;
    logic [NUM_MOLES-1:0] w_mole_oh;
    logic                 w_hit_ok;
    logic                 w_to_ok;
    logic                 w_score_inc;
    logic                 w_miss_inc;
    logic                 w_to_gap;
    logic [7:0]           w_score_new;
    logic                 w_level_up;

    assign w_idx_raw = 3'(r_lfsr[2:0] % NUM_MOLES);
    assign w_idx     = (w_idx_raw != r_prev_mole) ? w_idx_raw :
                       (w_idx_raw == LAST_IDX) ? 3'd0 : w_idx_raw + 3'd1;
    assign w_mole_oh = {{(NUM_MOLES-1){1'b0}}, 1'b1} << r_prev_mole;
    assign w_hit_ok  = |(hit & w_mole_oh);
    // Timer restart can leave a stale pulse in flight; blank the first two WAIT cycles.
    assign w_to_ok   = tmr_timeout && (r_blank_cnt == 2'd0);

    assign w_score_new = (r_score == 8'hFF) ? r_score : r_score + 8'd1;
    assign w_level_up  = (r_score != 8'hFF) && ((w_score_new % LEVEL_L) == 8'd0);

    always_comb begin
        w_state_nxt = r_state;
        w_score_inc = 1'b0;
        w_miss_inc  = 1'b0;
        w_to_gap    = 1'b0;
        case (r_state)
            S_IDLE, S_DONE: begin
                if (start) w_state_nxt = S_SPAWN;
            end
            S_SPAWN: w_state_nxt = S_WAIT;
            S_WAIT: begin
                if (w_hit_ok) begin
                    w_score_inc = 1'b1;
                    w_to_gap    = 1'b1;
                    w_state_nxt = S_GAP;
                end else if (w_to_ok) begin
                    w_miss_inc  = 1'b1;
                    w_to_gap    = 1'b1;
                    w_state_nxt = S_GAP;
                end
`ifdef WRONG_HIT_PENALTY_EN
                else if (|(hit & ~w_mole_oh)) begin
                    w_miss_inc = 1'b1;
                    if (r_misses + 4'd1 >= MAX_M) w_state_nxt = S_DONE;
                end
`endif
            end
            S_GAP: begin
                if (r_gap_cnt == '0) begin
                    if (r_misses >= MAX_M || r_round == ROUNDS_L) w_state_nxt = S_DONE;
                    else                                          w_state_nxt = S_SPAWN;
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= S_IDLE;
        else        r_state <= w_state_nxt;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_lfsr      <= 16'hACE1;
            r_prev_mole <= 3'd0;
            r_blank_cnt <= 2'd0;
            r_gap_cnt   <= '0;
            r_score     <= 8'd0;
            r_misses    <= 4'd0;
            r_round     <= 8'd0;
            r_interval  <= START_INT;
        end else begin
            // Galois form of x^16+x^14+x^13+x^11
            r_lfsr <= {1'b0, r_lfsr[15:1]} ^ (r_lfsr[0] ? 16'hB400 : 16'h0000);
            case (r_state)
                S_IDLE, S_DONE: begin
                    if (start) begin
                        r_score    <= 8'd0;
                        r_misses   <= 4'd0;
                        r_round    <= 8'd0;
                        r_interval <= START_INT;
                    end
                end
                S_SPAWN: begin
                    r_prev_mole <= w_idx;
                    r_blank_cnt <= 2'd2;
                end
                S_WAIT: begin
                    if (r_blank_cnt != 2'd0) r_blank_cnt <= r_blank_cnt - 2'd1;
                    if (w_score_inc) begin
                        r_score <= w_score_new;
                        if (w_level_up && r_interval > 3'd1) r_interval <= r_interval - 3'd1;
                    end
                    if (w_miss_inc && r_misses < MAX_M) r_misses <= r_misses + 4'd1;
                    if (w_to_gap) begin
                        r_gap_cnt <= GAP_LOAD;
                        if (r_round < ROUNDS_L) r_round <= r_round + 8'd1;
                    end
                end
                S_GAP: begin
                    if (r_gap_cnt != '0) r_gap_cnt <= r_gap_cnt - GW'(1);
                end
                default: ;
            endcase
        end
    end

    // Derived from state so reset blanks the mole without waiting for a clock edge.
    assign mole         = (r_state == S_WAIT) ? w_mole_oh : '0;
    assign tmr_rst_n    = (r_state == S_WAIT);
    assign tmr_dir      = 1'b0;
    assign tmr_interval = r_interval;
    assign score        = r_score;
    assign misses       = r_misses;
    assign round_cnt    = r_round;
    assign busy         = (r_state != S_IDLE) && (r_state != S_DONE);
    assign game_over    = (r_state == S_DONE);

endmodule

// File: tb/tb_whack_round_ctrl.sv
// Directed bench for whack_round_ctrl: full game of hits/timeouts, early game over, mid-round reset.
// Expected values come from a hand-maintained score model and a reference LFSR.
module tb_whack_round_ctrl;

    localparam int NM  = 8;
    localparam int RND = 24;
    localparam int GAP = 4;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          start = 1'b0;
    logic [NM-1:0] hit = '0;
    logic          tmr_timeout = 1'b0;
    logic          tmr_rst_n;
    logic [2:0]    tmr_interval;
    logic          tmr_dir;
    logic [NM-1:0] mole;
    logic [7:0]    score;
    logic [3:0]    misses;
    logic [7:0]    round_cnt;
    logic          busy;
    logic          game_over;

    int n_checks = 0;
    int n_errors = 0;

    int         exp_score, exp_misses, exp_round, exp_interval;
    logic [2:0] tb_prev;
    logic [15:0] tb_lfsr;

    whack_round_ctrl #(.NUM_MOLES(NM), .ROUNDS(RND), .MAX_MISSES(5), .START_INTERVAL(5),
                       .LEVEL_HITS(4), .GAP_CYCLES(GAP)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .hit(hit), .tmr_timeout(tmr_timeout),
        .tmr_rst_n(tmr_rst_n), .tmr_interval(tmr_interval), .tmr_dir(tmr_dir), .mole(mole),
        .score(score), .misses(misses), .round_cnt(round_cnt), .busy(busy), .game_over(game_over)
    );

    always #5 clk = ~clk;

    function automatic logic [15:0] lfsr_step(input logic [15:0] l);
        return l[0] ? ((l >> 1) ^ 16'hB400) : (l >> 1);
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) tb_lfsr <= 16'hACE1;
        else        tb_lfsr <= lfsr_step(tb_lfsr);
    end

    function automatic logic [NM-1:0] oh(input logic [2:0] i);
        logic [NM-1:0] one;
        one = 1;
        return one << i;
    endfunction

    task automatic check_val(input string tag, input logic [15:0] got, input logic [15:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic spawn_idx(output logic [2:0] e);
        e = 3'(tb_lfsr[2:0] % NM);
        if (e == tb_prev) e = (e == 3'(NM - 1)) ? 3'd0 : e + 3'd1;
        tb_prev = e;
    endtask

    task automatic start_game();
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        exp_score = 0; exp_misses = 0; exp_round = 0; exp_interval = 5;
        check_val("start_score", score, 0);
        check_val("start_misses", misses, 0);
        check_val("start_round", round_cnt, 0);
        check_val("start_interval", tmr_interval, 5);
        check_val("start_busy", busy, 1);
        check_val("start_game_over", game_over, 0);
    endtask

    // Entered in SPAWN; leaves in the cycle after GAP (SPAWN or DONE).
    // kind: 0 hit, 1 timeout, 2 hit and timeout together.
    task automatic play_round(input int kind, input int at_cyc, input bit ign_to, input bit stray_start);
        logic [2:0] e;
        spawn_idx(e);
        check_val("spawn_mole", mole, 0);
        check_val("spawn_tmr_rst", tmr_rst_n, 0);
        @(negedge clk);
        check_val("wait_mole", mole, oh(e));
        check_val("wait_tmr_rst", tmr_rst_n, 1);
        for (int c = 1; c <= at_cyc; c++) begin
            if (c == at_cyc) begin
                if (kind != 1) hit = oh(e);
                if (kind != 0) tmr_timeout = 1'b1;
            end else if (c == 1) begin
                if (ign_to) tmr_timeout = 1'b1;
                if (stray_start) start = 1'b1;
            end
            @(negedge clk);
            hit = '0; tmr_timeout = 1'b0; start = 1'b0;
            if (c < at_cyc) check_val("wait_hold_mole", mole, oh(e));
        end
        if (kind != 1) begin
            if (exp_score < 255) exp_score++;
            if (exp_score % 4 == 0 && exp_interval > 1) exp_interval--;
        end else begin
            exp_misses++;
        end
        exp_round++;
        check_val("gap_mole", mole, 0);
        check_val("gap_tmr_rst", tmr_rst_n, 0);
        check_val("gap_score", score, 16'(exp_score));
        check_val("gap_misses", misses, 16'(exp_misses));
        check_val("gap_round", round_cnt, 16'(exp_round));
        check_val("gap_interval", tmr_interval, 16'(exp_interval));
        repeat (GAP - 1) @(negedge clk);
        check_val("gap_last_mole", mole, 0);
        check_val("gap_last_busy", busy, 1);
        @(negedge clk);
    endtask

    initial begin
        logic [2:0] e;
        tb_prev = 3'd0;
        repeat (3) @(negedge clk);
        check_val("rst_mole", mole, 0);
        check_val("rst_tmr_rst", tmr_rst_n, 0);
        check_val("rst_interval", tmr_interval, 5);
        check_val("rst_busy", busy, 0);
        check_val("rst_game_over", game_over, 0);
        check_val("rst_score", score, 0);
        check_val("rst_dir", tmr_dir, 0);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        check_val("idle_busy", busy, 0);

        // Full game: every round played to the round limit.
        start_game();
        play_round(0, 10, 1'b0, 1'b0);
        play_round(1, 5, 1'b1, 1'b0);
        play_round(2, 3, 1'b0, 1'b0);
        play_round(0, 2, 1'b0, 1'b1);
        for (int r = 4; r < RND; r++) play_round(0, (r % 3) + 1, 1'b0, 1'b0);
        check_val("g1_game_over", game_over, 1);
        check_val("g1_busy", busy, 0);
        check_val("g1_round", round_cnt, 24);
        check_val("g1_score", score, 23);
        check_val("g1_interval_sat", tmr_interval, 1);
        repeat (3) @(negedge clk);
        check_val("g1_hold_score", score, 23);
        check_val("g1_hold_done", game_over, 1);

        // Early game over on misses.
        start_game();
        for (int r = 0; r < 5; r++) play_round(1, 3, 1'b0, 1'b0);
        check_val("g2_game_over", game_over, 1);
        check_val("g2_busy", busy, 0);
        check_val("g2_round", round_cnt, 5);
        check_val("g2_misses", misses, 5);

        // Wrong-bit press, then asynchronous reset mid-WAIT.
        start_game();
        spawn_idx(e);
        @(negedge clk);
        hit = oh(3'((int'(e) + 1) % NM));
        @(negedge clk);
        hit = '0;
`ifdef WRONG_HIT_PENALTY_EN
        check_val("wrong_hit_misses", misses, 1);
`else
        check_val("wrong_hit_misses", misses, 0);
`endif
        check_val("wrong_hit_mole", mole, oh(e));
        check_val("wrong_hit_busy", busy, 1);
        #2 rst_n = 1'b0;
        #1;
        check_val("async_rst_mole", mole, 0);
        check_val("async_rst_busy", busy, 0);
        check_val("async_rst_misses", misses, 0);
        check_val("async_rst_tmr_rst", tmr_rst_n, 0);
        tb_prev = 3'd0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check_val("post_rst_idle", busy, 0);

        // A fresh game after reset spawns from the restarted LFSR.
        start_game();
        play_round(0, 4, 1'b0, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
